// File: rtl/vga_pkg.sv
// Shared VGA pixel constants and helpers for the bouncing-box renderer.
package vga_pkg;

    localparam int RED_W        = 5;
    localparam int GREEN_W      = 6;
    localparam int BLUE_W       = 5;
    localparam int RESET_ORIGIN = 50;
    localparam int RESET_STRIDE = 15;

    typedef enum logic [1:0] {
        CH_RED   = 2'd0,
        CH_GREEN = 2'd1,
        CH_BLUE  = 2'd2
    } channel_e;

    function automatic channel_e channel_of(input int idx);
        case (idx % 3)
            0:       return CH_RED;
            1:       return CH_GREEN;
            default: return CH_BLUE;
        endcase
    endfunction

    // One bounce step on a single axis; returns {new_dir, new_pos}.
    // 11-bit intermediates keep 0-1 and max+1 distinguishable from legal values.
    function automatic logic [10:0] step_axis(input logic [9:0] pos,
                                              input logic dir,
                                              input logic [10:0] max_pos);
        logic [10:0] up;
        logic [10:0] down;
        up   = {1'b0, pos} + 11'd1;
        down = {1'b0, pos} - 11'd1;
        if (dir) begin
            if (up > max_pos) return {1'b0, down[9:0]};
            else              return {1'b1, up[9:0]};
        end else begin
            if (down[10]) return {1'b1, up[9:0]};
            else          return {1'b0, down[9:0]};
        end
    endfunction

endpackage

// File: rtl/box_mover.sv
// Position and direction state for one box; steps and bounces on each frame tick.
module box_mover
    import vga_pkg::*;
#(
    parameter int IDX      = 0,
    parameter int BOX_SIZE = 40,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       move_en,
    output logic [9:0] bx,
    output logic [9:0] by
);

    localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BOX_SIZE);

    logic [9:0] bx_reg, bx_next;
    logic [9:0] by_reg, by_next;
    logic       dx_reg, dx_next;
    logic       dy_reg, dy_next;
    logic [10:0] x_step;
    logic [10:0] y_step;

    always_comb begin
        x_step  = step_axis(bx_reg, dx_reg, X_MAX);
        y_step  = step_axis(by_reg, dy_reg, Y_MAX);
        bx_next = bx_reg;
        by_next = by_reg;
        dx_next = dx_reg;
        dy_next = dy_reg;
        if (tick && move_en) begin
            bx_next = x_step[9:0];
            dx_next = x_step[10];
            by_next = y_step[9:0];
            dy_next = y_step[10];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bx_reg <= 10'(RESET_ORIGIN + RESET_STRIDE * IDX);
            by_reg <= 10'(RESET_ORIGIN + RESET_STRIDE * IDX);
            dx_reg <= ((IDX % 2) == 0);
            dy_reg <= 1'b1;
        end else begin
            bx_reg <= bx_next;
            by_reg <= by_next;
            dx_reg <= dx_next;
            dy_reg <= dy_next;
        end
    end

    assign bx = bx_reg;
    assign by = by_reg;

endmodule

// File: rtl/box_renderer.sv
// Draws NUM_BOXES bouncing colour boxes; box positions only change on the
// frame tick at the start of vertical blank so a frame is never torn.
module box_renderer
    import vga_pkg::*;
#(
    parameter int NUM_BOXES = 3,
    parameter int BOX_SIZE  = 40,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         xpos,
    input  logic [9:0]         ypos,
    input  logic               move_en,
    output logic [RED_W-1:0]   red,
    output logic [GREEN_W-1:0] green,
    output logic [BLUE_W-1:0]  blue,
    output logic               frame_tick
);

    logic [9:0]           bx [NUM_BOXES];
    logic [9:0]           by [NUM_BOXES];
    logic [NUM_BOXES-1:0] hit;
    logic [9:0]           ypos_prev_reg;
    logic                 active;
    logic                 red_any, green_any, blue_any;
    logic [RED_W-1:0]     red_reg, red_next;
    logic [GREEN_W-1:0]   green_reg, green_next;
    logic [BLUE_W-1:0]    blue_reg, blue_next;

    assign frame_tick = !reset && (ypos == 10'(V_ACTIVE)) && (ypos != ypos_prev_reg);

    always_ff @(posedge clk) begin
        if (reset) ypos_prev_reg <= '0;
        else       ypos_prev_reg <= ypos;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BOXES; gi++) begin : gen_box
            box_mover #(
                .IDX      (gi),
                .BOX_SIZE (BOX_SIZE),
                .H_ACTIVE (H_ACTIVE),
                .V_ACTIVE (V_ACTIVE)
            ) u_mover (
                .clk     (clk),
                .reset   (reset),
                .tick    (frame_tick),
                .move_en (move_en),
                .bx      (bx[gi]),
                .by      (by[gi])
            );

            // Strict on both edges: the box outline pixels themselves are not drawn.
            assign hit[gi] = (xpos > bx[gi]) && ({1'b0, xpos} < ({1'b0, bx[gi]} + 11'(BOX_SIZE)))
                          && (ypos > by[gi]) && ({1'b0, ypos} < ({1'b0, by[gi]} + 11'(BOX_SIZE)));
        end
    endgenerate

    assign active = (xpos < 10'(H_ACTIVE)) && (ypos < 10'(V_ACTIVE));

    always_comb begin
        red_any   = 1'b0;
        green_any = 1'b0;
        blue_any  = 1'b0;
        for (int i = 0; i < NUM_BOXES; i++) begin
            case (channel_of(i))
                CH_RED:   red_any   = red_any   | hit[i];
                CH_GREEN: green_any = green_any | hit[i];
                default:  blue_any  = blue_any  | hit[i];
            endcase
        end
        red_next   = (active && red_any)   ? '1 : '0;
        green_next = (active && green_any) ? '1 : '0;
        blue_next  = (active && blue_any)  ? '1 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            red_reg   <= '0;
            green_reg <= '0;
            blue_reg  <= '0;
        end else begin
            red_reg   <= red_next;
            green_reg <= green_next;
            blue_reg  <= blue_next;
        end
    end

    assign red   = red_reg;
    assign green = green_reg;
    assign blue  = blue_reg;

endmodule

// File: tb/tb_box_renderer.sv
// Directed bench for box_renderer: rendering, edges, frame tick, motion and bounce.
module tb_box_renderer;

    logic       clk;
    logic       reset;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       move_en;
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
    logic       frame_tick;

    int total;
    int bad;

    box_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .xpos       (xpos),
        .ypos       (ypos),
        .move_en    (move_en),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Produces one ypos 479 -> 480 transition; pulses counts frame_tick cycles seen.
    task automatic send_tick(output int pulses);
        pulses = 0;
        @(negedge clk); ypos = 10'd479;
        #1 if (frame_tick) pulses++;
        @(negedge clk); ypos = 10'd480;
        #1 if (frame_tick) pulses++;
        @(negedge clk); ypos = 10'd0;
        #1 if (frame_tick) pulses++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; xpos = 10'd70; ypos = 10'd70; move_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (red !== 5'h00 || green !== 6'h00 || blue !== 5'h00 || frame_tick !== 1'b0) begin
            $display("FAIL reset_outputs: got r=%h g=%h b=%h ft=%b want all 0", red, green, blue, frame_tick);
            bad++;
        end
        total++;
        if (dut.bx[0] !== 10'd50 || dut.by[0] !== 10'd50 || dut.bx[1] !== 10'd65 || dut.bx[2] !== 10'd80) begin
            $display("FAIL reset_positions: got bx0=%0d by0=%0d bx1=%0d bx2=%0d want 50 50 65 80",
                     dut.bx[0], dut.by[0], dut.bx[1], dut.bx[2]);
            bad++;
        end
        total++;
        if (dut.gen_box[0].u_mover.dx_reg !== 1'b1 || dut.gen_box[1].u_mover.dx_reg !== 1'b0) begin
            $display("FAIL reset_dirs: got dx0=%b dx1=%b want 1 0",
                     dut.gen_box[0].u_mover.dx_reg, dut.gen_box[1].u_mover.dx_reg);
            bad++;
        end
        @(negedge clk); reset = 1'b0;
        $display("reset: done");
    endtask

    // At ypos 70 box 2 (by=80) is not covered, so blue stays 0 across the line.
    task automatic test_sweep();
        int errs;
        logic [4:0] exp_r;
        logic [5:0] exp_g;
        errs = 0;
        for (int x = 0; x < 640; x++) begin
            @(negedge clk); xpos = 10'(x); ypos = 10'd70;
            @(posedge clk); #1;
            exp_r = (x >= 51 && x <= 89)  ? 5'h1F : 5'h00;
            exp_g = (x >= 66 && x <= 104) ? 6'h3F : 6'h00;
            total++;
            if (red !== exp_r || green !== exp_g || blue !== 5'h00) begin
                if (errs < 10)
                    $display("FAIL sweep_x%0d: got r=%h g=%h b=%h want r=%h g=%h b=00",
                             x, red, green, blue, exp_r, exp_g);
                errs++;
                bad++;
            end
        end
        $display("sweep: 640 pixels at ypos 70, %0d wrong", errs);
    endtask

    task automatic test_pixels();
        logic [9:0] px [7];
        logic [9:0] py [7];
        logic [4:0] er [7];
        logic [5:0] eg [7];
        logic [4:0] eb [7];
        px[0] = 10'd51;  py[0] = 10'd51;  er[0] = 5'h1F; eg[0] = 6'h00; eb[0] = 5'h00;
        px[1] = 10'd50;  py[1] = 10'd60;  er[1] = 5'h00; eg[1] = 6'h00; eb[1] = 5'h00;
        px[2] = 10'd70;  py[2] = 10'd70;  er[2] = 5'h1F; eg[2] = 6'h3F; eb[2] = 5'h00;
        px[3] = 10'd91;  py[3] = 10'd91;  er[3] = 5'h00; eg[3] = 6'h3F; eb[3] = 5'h1F;
        px[4] = 10'd119; py[4] = 10'd119; er[4] = 5'h00; eg[4] = 6'h00; eb[4] = 5'h1F;
        px[5] = 10'd120; py[5] = 10'd100; er[5] = 5'h00; eg[5] = 6'h00; eb[5] = 5'h00;
        px[6] = 10'd60;  py[6] = 10'd90;  er[6] = 5'h00; eg[6] = 6'h00; eb[6] = 5'h00;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); xpos = px[k]; ypos = py[k];
            @(posedge clk); #1;
            total++;
            if (red !== er[k] || green !== eg[k] || blue !== eb[k]) begin
                $display("FAIL pixel_%0d_%0d: got r=%h g=%h b=%h want r=%h g=%h b=%h",
                         px[k], py[k], red, green, blue, er[k], eg[k], eb[k]);
                bad++;
            end
            $display("pixel (%0d,%0d): r=%h g=%h b=%h", px[k], py[k], red, green, blue);
        end
    endtask

    task automatic test_tick_hold();
        int pulses;
        pulses = 0;
        move_en = 1'b1;
        @(negedge clk); ypos = 10'd479; xpos = 10'd0;
        #1 if (frame_tick) pulses++;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk); ypos = 10'd480;
            #1 if (frame_tick) pulses++;
        end
        total++;
        if (pulses !== 1) begin
            $display("FAIL tick_hold_pulses: got %0d want 1", pulses);
            bad++;
        end
        total++;
        if (dut.bx[0] !== 10'd51 || dut.by[0] !== 10'd51 || dut.bx[1] !== 10'd64 || dut.by[1] !== 10'd66) begin
            $display("FAIL tick_move: got box0=(%0d,%0d) box1=(%0d,%0d) want (51,51) (64,66)",
                     dut.bx[0], dut.by[0], dut.bx[1], dut.by[1]);
            bad++;
        end
        @(negedge clk); ypos = 10'd0;
        $display("tick_hold: pulses=%0d box0=(%0d,%0d)", pulses, dut.bx[0], dut.by[0]);
    endtask

    task automatic test_freeze();
        int pulses;
        int sum;
        sum = 0;
        move_en = 1'b0;
        for (int t = 0; t < 3; t++) begin
            send_tick(pulses);
            sum += pulses;
        end
        total++;
        if (sum !== 3) begin
            $display("FAIL freeze_pulses: got %0d want 3", sum);
            bad++;
        end
        total++;
        if (dut.bx[0] !== 10'd51 || dut.by[0] !== 10'd51 || dut.bx[1] !== 10'd64 || dut.by[1] !== 10'd66) begin
            $display("FAIL freeze_positions: got box0=(%0d,%0d) box1=(%0d,%0d) want (51,51) (64,66)",
                     dut.bx[0], dut.by[0], dut.bx[1], dut.by[1]);
            bad++;
        end
        $display("freeze: 3 ticks, box0=(%0d,%0d)", dut.bx[0], dut.by[0]);
    endtask

    task automatic test_out_of_range();
        @(negedge clk); xpos = 10'd700; ypos = 10'd70;
        @(posedge clk); #1;
        total++;
        if (red !== 5'h00 || green !== 6'h00 || blue !== 5'h00) begin
            $display("FAIL blank_x700: got r=%h g=%h b=%h want 0", red, green, blue);
            bad++;
        end
        @(negedge clk); xpos = 10'd70; ypos = 10'd500;
        @(posedge clk); #1;
        total++;
        if (red !== 5'h00 || green !== 6'h00 || blue !== 5'h00) begin
            $display("FAIL blank_y500: got r=%h g=%h b=%h want 0", red, green, blue);
            bad++;
        end
        $display("out_of_range: checked x700 and y500");
        @(negedge clk); ypos = 10'd0;
    endtask

    // Box 0 walks from 51 to the right bound 600, bounces to 599, walks to 0, bounces to 1.
    task automatic test_bounce();
        int pulses;
        move_en = 1'b1;
        for (int t = 0; t < 549; t++) send_tick(pulses);
        total++;
        if (dut.bx[0] !== 10'd600 || dut.gen_box[0].u_mover.dx_reg !== 1'b1) begin
            $display("FAIL bounce_at_600: got bx=%0d dx=%b want 600 1", dut.bx[0], dut.gen_box[0].u_mover.dx_reg);
            bad++;
        end
        send_tick(pulses);
        total++;
        if (dut.bx[0] !== 10'd599 || dut.gen_box[0].u_mover.dx_reg !== 1'b0) begin
            $display("FAIL bounce_right: got bx=%0d dx=%b want 599 0", dut.bx[0], dut.gen_box[0].u_mover.dx_reg);
            bad++;
        end
        $display("bounce right: bx=%0d", dut.bx[0]);
        for (int t = 0; t < 599; t++) send_tick(pulses);
        total++;
        if (dut.bx[0] !== 10'd0 || dut.gen_box[0].u_mover.dx_reg !== 1'b0) begin
            $display("FAIL bounce_at_0: got bx=%0d dx=%b want 0 0", dut.bx[0], dut.gen_box[0].u_mover.dx_reg);
            bad++;
        end
        send_tick(pulses);
        total++;
        if (dut.bx[0] !== 10'd1 || dut.gen_box[0].u_mover.dx_reg !== 1'b1) begin
            $display("FAIL bounce_left: got bx=%0d dx=%b want 1 1", dut.bx[0], dut.gen_box[0].u_mover.dx_reg);
            bad++;
        end
        $display("bounce left: bx=%0d", dut.bx[0]);
    endtask

    task automatic test_reset_on_tick();
        move_en = 1'b1;
        @(negedge clk); ypos = 10'd479; xpos = 10'd70;
        @(negedge clk); ypos = 10'd480; reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (dut.bx[0] !== 10'd50 || dut.by[0] !== 10'd50 || dut.bx[1] !== 10'd65 || dut.by[1] !== 10'd65
            || dut.bx[2] !== 10'd80 || dut.by[2] !== 10'd80) begin
            $display("FAIL reset_tick_positions: got (%0d,%0d) (%0d,%0d) (%0d,%0d) want (50,50) (65,65) (80,80)",
                     dut.bx[0], dut.by[0], dut.bx[1], dut.by[1], dut.bx[2], dut.by[2]);
            bad++;
        end
        total++;
        if (red !== 5'h00 || green !== 6'h00 || blue !== 5'h00 || frame_tick !== 1'b0) begin
            $display("FAIL reset_tick_outputs: got r=%h g=%h b=%h ft=%b want all 0", red, green, blue, frame_tick);
            bad++;
        end
        @(negedge clk); reset = 1'b0; ypos = 10'd0;
        $display("reset_on_tick: box0=(%0d,%0d)", dut.bx[0], dut.by[0]);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        xpos = 10'd0;
        ypos = 10'd0;
        move_en = 1'b0;
        test_reset();
        test_sweep();
        test_pixels();
        test_tick_hold();
        test_freeze();
        test_out_of_range();
        test_bounce();
        test_reset_on_tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
